nanb_game_ctrl: RTL

NANB_GAME_CTRL -- requirements
Module: nanb_game_ctrl

---
 rtl/nanb_pkg.sv | 38 +++
 rtl/seg7_decoder.sv | 32 +++
 rtl/nanb_game_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/nanb_pkg.sv
// nanb_pkg: shared types and constants for the nA-nB guessing game controller.
package nanb_pkg;

  // Game controller states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PLAY = 3'd1,
    EVAL = 3'd2,
    WIN  = 3'd3,
    LOSE = 3'd4
  } gameStateT;

  // Active-low 7-segment letter patterns, bit order gfedcba.
  localparam logic [6:0] SEG_LTR_A = 7'h08;
  localparam logic [6:0] SEG_LTR_B = 7'h03;
  localparam logic [6:0] SEG_LTR_E = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Face patterns for HEX4..HEX0, HEX0 in the LSBs.
  localparam logic [34:0] WIN_FACE  = {7'h5C, 7'h77, 7'h77, 7'h5C, 7'h03};
  localparam logic [34:0] LOSE_FACE = {7'h1C, 7'h77, 7'h77, 7'h1C, 7'h0C};

  // A value is legal when its first n digits are all BCD and pairwise distinct.
  function automatic logic isValidBcd(input logic [23:0] v, input int unsigned n);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      if (i < n) begin
        if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        for (int unsigned j = 0; j < 6; j++) begin
          if ((j < n) && (j > i) && (v[4*i +: 4] == v[4*j +: 4])) ok = 1'b0;
        end
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: hex digit to active-low 7-segment pattern (gfedcba).
module seg7_decoder
  import nanb_pkg::*;
(
  input  logic [3:0] iDigit,
  output logic [6:0] oSeg_c
);

  // Digit lookup.
  always_comb begin
    oSeg_c = SEG_BLANK;
    case (iDigit)
      4'h0: oSeg_c = 7'h40;
      4'h1: oSeg_c = 7'h79;
      4'h2: oSeg_c = 7'h24;
      4'h3: oSeg_c = 7'h30;
      4'h4: oSeg_c = 7'h19;
      4'h5: oSeg_c = 7'h12;
      4'h6: oSeg_c = 7'h02;
      4'h7: oSeg_c = 7'h78;
      4'h8: oSeg_c = 7'h00;
      4'h9: oSeg_c = 7'h10;
      4'hA: oSeg_c = 7'h08;
      4'hB: oSeg_c = 7'h03;
      4'hC: oSeg_c = 7'h46;
      4'hD: oSeg_c = 7'h21;
      4'hE: oSeg_c = 7'h06;
      4'hF: oSeg_c = 7'h0E;
    endcase
  end

endmodule

// File: rtl/nanb_game_ctrl.sv
// nanb_game_ctrl: nA-nB (bulls and cows) game controller with 7-seg score display.
// Optional button debouncer enabled by defining NANB_DEBOUNCE_EN.
module nanb_game_ctrl
  import nanb_pkg::*;
#(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned MAX_TRIES       = 5,
  parameter int unsigned HOLD_CYCLES     = 100000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iBtn,
  input  logic                  iLoad,
  input  logic [4*DIGITS-1:0]   iAnswer,
  input  logic [4*DIGITS-1:0]   iGuess,
  output logic [41:0]           oHex,
  output logic [MAX_TRIES-1:0]  oLED,
  output logic                  oErr,
  output logic                  oWin,
  output logic                  oLose
);

  localparam int unsigned VW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned TW = $clog2(MAX_TRIES + 1);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  // Parameter legality checks at elaboration.
  if (DIGITS < 1 || DIGITS > 6) begin : gBadDigits
    $error("DIGITS must be 1..6");
  end
  if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : gBadTries
    $error("MAX_TRIES must be 1..15");
  end
  if (HOLD_CYCLES < 1) begin : gBadHold
    $error("HOLD_CYCLES must be at least 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : gBadDebounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  gameStateT          state;
  logic [VW-1:0]      answerReg;
  logic [VW-1:0]      guessReg;
  logic [CW-1:0]      curA, curB, cntA, cntB, nxtA, nxtB;
  logic [TW-1:0]      tries, nxtTries;
  logic [HW-1:0]      holdCnt;
  logic               btnMeta, btnSync, btnLevel, btnPrev, btnEdge;
  logic               answerOk, guessOk, loadOk;
  logic [6:0]         segA, segB, segTries;
  logic [41:0]        scoreHex;

  // Two-flop synchroniser and edge-detect history.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      btnMeta <= 1'b0;
      btnSync <= 1'b0;
      btnPrev <= 1'b0;
    end else begin
      btnMeta <= iBtn;
      btnSync <= btnMeta;
      btnPrev <= btnLevel;
    end
  end

`ifdef NANB_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DW-1:0] dbCnt;
  logic          dbLevel;

  // Accept a new button level only after it has been stable long enough.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      dbCnt   <= '0;
      dbLevel <= 1'b0;
    end else if (btnSync == dbLevel) begin
      dbCnt <= '0;
    end else if (dbCnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      dbLevel <= btnSync;
      dbCnt   <= '0;
    end else begin
      dbCnt <= dbCnt + DW'(1);
    end
  end

  assign btnLevel = dbLevel;
`else
  assign btnLevel = btnSync;
`endif

  assign btnEdge  = btnLevel & ~btnPrev;
  assign answerOk = isValidBcd(24'(iAnswer), DIGITS);
  assign guessOk  = isValidBcd(24'(guessReg), DIGITS);
  assign loadOk   = iLoad & answerOk;

  // Exact-position (A) and misplaced (B) digit matches.
  always_comb begin
    cntA = '0;
    cntB = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      for (int unsigned j = 0; j < DIGITS; j++) begin
        if (guessReg[4*i +: 4] == answerReg[4*j +: 4]) begin
          if (i == j) cntA = cntA + CW'(1);
          else        cntB = cntB + CW'(1);
        end
      end
    end
  end

  // Score values that will be visible after this clock edge.
  always_comb begin
    nxtA     = curA;
    nxtB     = curB;
    nxtTries = tries;
    if (loadOk) begin
      nxtA     = '0;
      nxtB     = '0;
      nxtTries = TW'(MAX_TRIES);
    end else if ((state == EVAL) && guessOk) begin
      nxtA = cntA;
      nxtB = cntB;
      if (cntA != CW'(DIGITS)) begin
        nxtTries = (tries == '0) ? '0 : tries - TW'(1);
      end
    end
  end

  seg7_decoder uSegB     (.iDigit(4'(nxtB)),     .oSeg_c(segB));
  seg7_decoder uSegA     (.iDigit(4'(nxtA)),     .oSeg_c(segA));
  seg7_decoder uSegTries (.iDigit(4'(nxtTries)), .oSeg_c(segTries));

  assign scoreHex = {SEG_BLANK, segTries, segA, SEG_LTR_A, segB, SEG_LTR_B};

  // Thermometer code of the tries remaining.
  function automatic logic [MAX_TRIES-1:0] thermo(input logic [TW-1:0] n);
    logic [MAX_TRIES-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < MAX_TRIES; i++) t[i] = (32'(n) > i);
    return t;
  endfunction

  // Game FSM with registered display, LEDs and status flags.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state     <= IDLE;
      answerReg <= '0;
      guessReg  <= '0;
      curA      <= '0;
      curB      <= '0;
      tries     <= TW'(MAX_TRIES);
      holdCnt   <= '0;
      oHex      <= '1;
      oLED      <= '1;
      oErr      <= 1'b0;
      oWin      <= 1'b0;
      oLose     <= 1'b0;
    end else begin
      oErr  <= 1'b0;
      curA  <= nxtA;
      curB  <= nxtB;
      tries <= nxtTries;
      oLED  <= thermo(nxtTries);
      if (loadOk) begin
        // A new game wins over any button edge in the same cycle.
        answerReg <= iAnswer;
        holdCnt   <= '0;
        oHex      <= scoreHex;
        oWin      <= 1'b0;
        oLose     <= 1'b0;
        state     <= PLAY;
      end else begin
        if (iLoad) oErr <= 1'b1;
        case (state)
          IDLE: ;
          PLAY: begin
            if (btnEdge && !iLoad) begin
              guessReg <= iGuess;
              state    <= EVAL;
            end
          end
          EVAL: begin
            if (!guessOk) begin
              oErr  <= 1'b1;
              oHex  <= {scoreHex[41:7], SEG_LTR_E};
              state <= PLAY;
            end else if (cntA == CW'(DIGITS)) begin
              oHex    <= scoreHex;
              holdCnt <= '0;
              oWin    <= 1'b1;
              state   <= WIN;
            end else begin
              oHex <= scoreHex;
              if (nxtTries == '0) begin
                holdCnt <= '0;
                oLose   <= 1'b1;
                state   <= LOSE;
              end else begin
                state <= PLAY;
              end
            end
          end
          WIN, LOSE: begin
            if (holdCnt != HOLD_MAX) begin
              holdCnt <= holdCnt + HW'(1);
              if (holdCnt == HOLD_LAST) begin
                oHex <= {SEG_BLANK, (state == WIN) ? WIN_FACE : LOSE_FACE};
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
